// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter_if
// Brief    : Fetch, data and unified-memory signal bundle for the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int c_BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [c_BE_W-1:0] d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [c_BE_W-1:0] mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter side
    modport master (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    // Requesters and memory side
    modport slave (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_arbiter
// Brief    : Shares one memory port between instruction fetch and data access.
// Revision : 1.0  initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input wire                  clk,
    input wire                  reset,
    riscv_mem_arbiter_if.master bus
);
    localparam int         c_BE_W    = DATA_W / 8;
    localparam logic [3:0] c_LIM     = 4'(STARVE_LIM);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_starve;
    logic              r_discard;
    logic              r_sel_d;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [c_BE_W-1:0] r_mem_be;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;

    logic w_idle;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_if;
    logic w_ack;
    logic w_flush_hit;

    assign w_idle      = (r_state == c_IDLE);
    assign w_starved   = (r_starve == c_LIM);
    assign w_grant_d   = w_idle & bus.d_req & (~bus.if_req | ~w_starved);
    assign w_grant_if  = w_idle & bus.if_req & ~w_grant_d;
    assign w_ack       = r_mem_req & bus.mem_ack;
    // A redirect kills the fetch whether it is being granted or already in flight
    assign w_flush_hit = bus.if_flush & (w_grant_if | (r_state == c_BUSY_IF));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_starve    <= 4'd0;
            r_discard   <= 1'b0;
            r_sel_d     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (w_flush_hit) begin
                r_discard <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_be    <= bus.d_be;
                        r_sel_d     <= 1'b1;
                        r_state     <= c_BUSY_D;
                        if (bus.if_req && !w_starved) begin
                            r_starve <= r_starve + 4'd1;
                        end
                    end else if (w_grant_if) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.if_addr;
                        r_mem_be   <= '1;
                        r_sel_d    <= 1'b0;
                        r_starve   <= 4'd0;
                        r_state    <= c_BUSY_IF;
                    end
                end
                c_BUSY_IF, c_BUSY_D: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_sel_d) begin
                            r_d_rdata <= bus.mem_rdata;
                        end else if (!(r_discard || w_flush_hit)) begin
                            r_if_rdata <= bus.mem_rdata;
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_d_valid  <= r_sel_d;
                    r_if_valid <= ~r_sel_d & ~r_discard;
                    r_discard  <= 1'b0;
                    r_state    <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.if_stall  = bus.if_req & ~r_if_valid;
    assign bus.d_stall   = bus.d_req & ~r_d_valid;
endmodule
`default_nettype wire
